// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned LANE_W = 2;

    localparam logic [SEL_W-1:0] MEM_SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Attributes of the in-flight access needed after the issue cycle
    typedef struct packed {
        logic              read;
        logic              sign_ext;
        logic              word;
        logic [LANE_W-1:0] lane;
    } mem_req_t;

    // Byte stores are replicated to every lane; the strobe picks the real one
    function automatic logic [DATA_W-1:0] align_store(input logic word,
                                                      input logic [DATA_W-1:0] data);
        return word ? data : {4{data[7:0]}};
    endfunction

    // Per-lane write strobe for a select pattern placed at a byte lane
    function automatic logic [SEL_W-1:0] lane_strobe(input logic [SEL_W-1:0] sel,
                                                     input logic [LANE_W-1:0] lane);
        return SEL_W'(sel << lane);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte lane and sign/zero extends it.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] rd_data,
    input  logic [LANE_W-1:0] lane,
    input  logic              word,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0] lane_byte;

    // Lane select (lane 0 = bits 7:0) and extension
    always_comb begin
        lane_byte = rd_data[7:0];
        case (lane)
            2'd0:    lane_byte = rd_data[7:0];
            2'd1:    lane_byte = rd_data[15:8];
            2'd2:    lane_byte = rd_data[23:16];
            default: lane_byte = rd_data[31:24];
        endcase
        if (word) begin
            data_c = rd_data;
        end else begin
            data_c = {{24{sign_ext & lane_byte[7]}}, lane_byte};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues aligned RAM requests, waits for ram_ready with
// a timeout, returns extended load data and stalls the pipeline meanwhile.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic              mem_sign_ext_flag,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              ram_en,
    output logic [SEL_W-1:0]  ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data,
    input  logic              ram_ready,
    output logic              stall_request,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              addr_error,
    output logic              bus_error
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    mem_req_t              req_q, req_d;
    logic                  drop_q, drop_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  ram_en_d;
    logic [SEL_W-1:0]      ram_write_en_d;
    logic [ADDR_W-1:0]     ram_addr_d;
    logic [DATA_W-1:0]     ram_write_data_d;
    logic [DATA_W-1:0]     load_data_d;
    logic                  load_valid_d;
    logic                  addr_error_d;
    logic                  bus_error_d;

    logic                  req_c;
    logic                  is_word_c;
    logic                  misaligned_c;
    logic                  drop_now_c;
    logic [DATA_W-1:0]     aligned_load_c;

    assign req_c        = (mem_read_flag | mem_write_flag) & (|mem_sel) & ~flush;
    assign is_word_c    = (mem_sel == MEM_SEL_WORD);
    assign misaligned_c = is_word_c & (|mem_addr[1:0]);
    assign drop_now_c   = drop_q | flush;

    // Lane extraction of the returning read data for the latched access
    mem_load_align u_load_align (
        .rd_data  (ram_read_data),
        .lane     (req_q.lane),
        .word     (req_q.word),
        .sign_ext (req_q.sign_ext),
        .data_c   (aligned_load_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            drop_q         <= 1'b0;
            cnt_q          <= '0;
            ram_en         <= 1'b0;
            ram_write_en   <= '0;
            ram_addr       <= '0;
            ram_write_data <= '0;
            load_data      <= '0;
            load_valid     <= 1'b0;
            addr_error     <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            drop_q         <= drop_d;
            cnt_q          <= cnt_d;
            ram_en         <= ram_en_d;
            ram_write_en   <= ram_write_en_d;
            ram_addr       <= ram_addr_d;
            ram_write_data <= ram_write_data_d;
            load_data      <= load_data_d;
            load_valid     <= load_valid_d;
            addr_error     <= addr_error_d;
            bus_error      <= bus_error_d;
        end
    end

    // Next state, next registered outputs and the combinational stall
    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        drop_d           = drop_q;
        cnt_d            = cnt_q;
        ram_en_d         = 1'b0;
        ram_write_en_d   = '0;
        ram_addr_d       = ram_addr;
        ram_write_data_d = ram_write_data;
        load_data_d      = load_data;
        load_valid_d     = 1'b0;
        addr_error_d     = 1'b0;
        bus_error_d      = 1'b0;
        stall_request    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (req_c) begin
                    if (misaligned_c) begin
                        addr_error_d = 1'b1;
                    end else begin
                        stall_request    = 1'b1;
                        req_d.read       = mem_read_flag;
                        req_d.sign_ext   = mem_sign_ext_flag;
                        req_d.word       = is_word_c;
                        req_d.lane       = mem_addr[1:0];
                        ram_en_d         = 1'b1;
                        ram_write_en_d   = mem_read_flag ? MEM_SEL_NONE
                                                         : lane_strobe(mem_sel, mem_addr[1:0]);
                        ram_addr_d       = {mem_addr[ADDR_W-1:2], 2'b00};
                        ram_write_data_d = align_store(is_word_c, mem_write_data);
                        state_d          = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                stall_request = 1'b1;
                drop_d        = drop_now_c;
                if (ram_ready) begin
                    cnt_d = '0;
                    if (req_q.read) begin
                        load_data_d = aligned_load_c;
                    end
                    if (drop_now_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        load_valid_d = req_q.read;
                        state_d      = ST_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d          = cnt_q + CNT_WIDTH'(1);
                    ram_en_d       = 1'b1;
                    ram_write_en_d = ram_write_en;
                end
            end

            ST_DONE: begin
                drop_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a randomised RAM responder.
module tb_mem_access_ctrl;

    localparam int TO = 4;
    localparam int K_RAM  = 0;
    localparam int K_LOAD = 1;
    localparam int K_AERR = 2;
    localparam int K_BERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic        mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data;
    logic [31:0] mem_addr;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        ram_ready;
    logic        stall_request;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_error;
    logic        bus_error;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    int          cur_wait  = 0;
    logic [31:0] cur_rdata = '0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .mem_sel           (mem_sel),
        .mem_write_data    (mem_write_data),
        .mem_addr          (mem_addr),
        .ram_en            (ram_en),
        .ram_write_en      (ram_write_en),
        .ram_addr          (ram_addr),
        .ram_write_data    (ram_write_data),
        .ram_read_data     (ram_read_data),
        .ram_ready         (ram_ready),
        .stall_request     (stall_request),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .addr_error        (addr_error),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.addr = a; e.we = we; e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every observed DUT event pops the oldest expectation
    task automatic take(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind && kind == K_RAM) begin
                chk("ram_addr", ram_addr, e.addr);
                chk("ram_write_en", 32'(ram_write_en), 32'(e.we));
                if (e.we != 4'h0) chk("ram_write_data", ram_write_data, e.data);
            end
            if (kind == e.kind && kind == K_LOAD) chk("load_data", load_data, e.data);
        end
    endtask

    initial begin : monitor
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_en = 1'b0;
            end else begin
                if (addr_error) take(K_AERR);
                if (bus_error)  take(K_BERR);
                if (load_valid) take(K_LOAD);
                if (ram_en && !prev_en) take(K_RAM);
                prev_en = ram_en;
            end
        end
    end

    // RAM model: answers after cur_wait extra cycles; random ready noise when idle
    initial begin : responder
        int busy_cnt;
        logic was_en;
        busy_cnt = 0;
        was_en = 1'b0;
        ram_ready = 1'b0;
        ram_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ram_en) begin
                busy_cnt = was_en ? busy_cnt + 1 : 0;
                ram_ready = (busy_cnt == cur_wait);
                ram_read_data = ram_ready ? cur_rdata : $urandom;
            end else begin
                busy_cnt = 0;
                ram_ready = 1'($urandom_range(0, 1));
                ram_read_data = $urandom;
            end
            was_en = ram_en;
        end
    end

    task automatic idle_inputs();
        flush = 1'b0; mem_read_flag = 1'b0; mem_write_flag = 1'b0;
        mem_sign_ext_flag = 1'b0; mem_sel = 4'h0; mem_write_data = '0; mem_addr = '0;
    endtask

    // One pipeline instruction: builds expectations from the behavioural rules,
    // drives it until the pipeline is allowed to advance, checks stall length
    task automatic do_op(input logic rd, input logic wr, input logic sext,
                         input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wt,
                         input logic [31:0] rdata, input int flush_at);
        int exp_stall, stall_cnt, busy, k, lane;
        logic word;
        logic [31:0] v;
        word = (sel == 4'hF);
        lane = int'(addr & 32'd3);
        exp_stall = 0;
        if ((rd || wr) && sel != 4'h0 && flush_at != 0) begin
            if (word && lane != 0) begin
                push(K_AERR, 0, 0, 0);
            end else begin
                busy = (wt < TO) ? wt + 1 : TO;
                exp_stall = 1 + busy;
                push(K_RAM, addr & ~32'd3, rd ? 4'h0 : (word ? 4'hF : 4'(1 << lane)),
                     word ? wdata : (wdata & 32'hFF) * 32'h01010101);
                if (wt >= TO) begin
                    push(K_BERR, 0, 0, 0);
                end else if (rd && !(flush_at >= 1)) begin
                    if (word) v = rdata;
                    else begin
                        v = (rdata >> (8 * lane)) & 32'hFF;
                        if (sext && v >= 32'd128) v = v | 32'hFFFFFF00;
                    end
                    push(K_LOAD, 0, 0, v);
                end
            end
        end
        cur_wait = wt;
        cur_rdata = rdata;
        mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sext;
        mem_sel = sel; mem_addr = addr; mem_write_data = wdata;
        flush = (flush_at == 0);
        stall_cnt = 0;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (!stall_request) break;
            stall_cnt++;
            if (stall_cnt > 64) break;
            @(posedge clk);
            #1;
            k++;
            if (k == flush_at) flush = 1'b1;
        end
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] a;
        logic [3:0]  s;
        logic        r;
        int          w, fa, bsy;
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_write_en", 32'(ram_write_en), 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_stall", 32'(stall_request), 0);
        chk("rst_load_valid", 32'(load_valid), 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_errors", {30'd0, addr_error, bus_error}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        do_op(0, 1, 0, 4'hF, 32'h100, 32'hDEADBEEF, 1, 32'h0, -1);
        do_op(1, 0, 1, 4'h1, 32'h103, 32'h0, 0, 32'h80112233, -1);
        do_op(1, 0, 0, 4'h1, 32'h103, 32'h0, 0, 32'h80112233, -1);
        do_op(0, 1, 0, 4'h1, 32'h202, 32'h000000A5, 0, 32'h0, -1);
        do_op(1, 0, 0, 4'hF, 32'h006, 32'h0, 0, 32'h0, -1);
        do_op(1, 0, 0, 4'hF, 32'h040, 32'h0, 3, 32'h12345678, 2);
        do_op(1, 0, 0, 4'hF, 32'h044, 32'h0, 1000, 32'h0, -1);
        do_op(1, 0, 0, 4'hF, 32'h048, 32'h0, TO - 1, 32'hCAFEF00D, -1);
        do_op(0, 1, 0, 4'hF, 32'h04C, 32'h11111111, 0, 32'h0, 0);
        do_op(1, 0, 0, 4'h0, 32'h050, 32'h0, 0, 32'h0, -1);

        for (int i = 0; i < 150; i++) begin
            r = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0) ? 4'h0 : (($urandom_range(0, 1) == 1) ? 4'hF : 4'h1);
            a = $urandom;
            if (s == 4'hF && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, TO - 1));
            bsy = (w < TO) ? w + 1 : TO;
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, bsy)) : -1;
            do_op(r, ~r, 1'($urandom_range(0, 1)), s, a, $urandom, w, $urandom, fa);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        cur_wait = 1000;
        push(K_RAM, 32'h300, 4'h0, 32'h0);
        mem_read_flag = 1'b1; mem_sel = 4'hF; mem_addr = 32'h300;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("async_rst_ram_en", 32'(ram_en), 0);
        chk("async_rst_stall", 32'(stall_request), 0);
        chk("async_rst_write_en", 32'(ram_write_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_op(1, 0, 1, 4'h1, 32'h301, 32'h0, 0, 32'h0000FE00, -1);

        repeat (8) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
